gmem_bram_responder: RTL and testbench

AXI4 full-protocol slave that services the kernel's 512-bit `gmem` master port from on-chip block RAM. It is the responder end of the `gmem` interface driven by the GLM kernel top, and is used in place of device DDR for kernel-level simulation and small on-chip datasets. It handles one burst at a time, with fair read/write arbitration, INCR bursts, byte-strobed writes and ID echo.

---
 rtl/gmem_bram_responder_if.sv | 63 ++++++
 rtl/gmem_bram_responder.sv | 172 +++++++++++++++++
 tb/tb_gmem_bram_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmem_bram_responder_if.sv
// rtl/gmem_bram_responder_if.sv - AXI4 gmem bus bundle between kernel master and BRAM responder
interface gmem_bram_responder_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512
);

  // Write address channel
  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [ID_WIDTH-1:0]     AWID;
  logic [7:0]              AWLEN;

  // Write data channel
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;

  // Write response channel
  logic                    BVALID;
  logic                    BREADY;
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;

  // Read address channel
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [ID_WIDTH-1:0]     ARID;
  logic [7:0]              ARLEN;

  // Read data channel
  logic                    RVALID;
  logic                    RREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [ID_WIDTH-1:0]     RID;
  logic [1:0]              RRESP;
  logic                    RLAST;

  modport master (
    output AWVALID, AWADDR, AWID, AWLEN,
    output WVALID, WDATA, WSTRB, WLAST,
    output BREADY,
    output ARVALID, ARADDR, ARID, ARLEN,
    output RREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP,
    input  ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );

  modport slave (
    input  AWVALID, AWADDR, AWID, AWLEN,
    input  WVALID, WDATA, WSTRB, WLAST,
    input  BREADY,
    input  ARVALID, ARADDR, ARID, ARLEN,
    input  RREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP,
    output ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );

endinterface

// File: rtl/gmem_bram_responder.sv
// rtl/gmem_bram_responder.sv - single-burst AXI4 slave serving the 512-bit gmem port from block RAM
module gmem_bram_responder #(
  parameter int C_M_AXI_GMEM_ID_WIDTH   = 1,
  parameter int C_M_AXI_GMEM_ADDR_WIDTH = 42,
  parameter int C_M_AXI_GMEM_DATA_WIDTH = 512,
  parameter int MEM_DEPTH_LOG2          = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  gmem_bram_responder_if.slave  s_axi_gmem
);

  localparam int ID_W   = C_M_AXI_GMEM_ID_WIDTH;
  localparam int ADDR_W = C_M_AXI_GMEM_ADDR_WIDTH;
  localparam int DATA_W = C_M_AXI_GMEM_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = MEM_DEPTH_LOG2;
  localparam int DEPTH  = 1 << MEM_DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    RD_FETCH,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t              state;
  logic                prio_write;
  logic [ID_W-1:0]     id_q;
  logic [7:0]          len_q;
  logic [7:0]          beat;
  logic [IDX_W-1:0]    idx;

  logic                rvalid;
  logic                rlast;
  logic [DATA_W-1:0]   rdata;
  logic                wready;
  logic                bvalid;

  logic                idle;
  logic                ar_grant;
  logic                aw_grant;
  logic                w_fire;
  logic                last_beat;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  // Only the line index field of each address selects RAM; everything else is don't-care.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_gmem.WLAST,
                              s_axi_gmem.AWADDR[5:0], s_axi_gmem.AWADDR[ADDR_W-1:IDX_W+6],
                              s_axi_gmem.ARADDR[5:0], s_axi_gmem.ARADDR[ADDR_W-1:IDX_W+6]};

  // Grants are only offered from IDLE and never while reset is held, so a
  // handshake can never coincide with reset. When both sides request, the
  // priority bit picks the winner; otherwise the lone requester wins.
  assign idle     = (state == IDLE) && !ap_rst;
  assign ar_grant = idle && s_axi_gmem.ARVALID && (!s_axi_gmem.AWVALID || !prio_write);
  assign aw_grant = idle && s_axi_gmem.AWVALID && (!s_axi_gmem.ARVALID ||  prio_write);
  assign w_fire   = wready && s_axi_gmem.WVALID && !ap_rst;
  assign last_beat = (beat == len_q);

  assign s_axi_gmem.ARREADY = ar_grant;
  assign s_axi_gmem.AWREADY = aw_grant;
  assign s_axi_gmem.WREADY  = wready;
  assign s_axi_gmem.BVALID  = bvalid;
  assign s_axi_gmem.BID     = id_q;
  assign s_axi_gmem.BRESP   = 2'b00;
  assign s_axi_gmem.RVALID  = rvalid;
  assign s_axi_gmem.RDATA   = rdata;
  assign s_axi_gmem.RID     = id_q;
  assign s_axi_gmem.RRESP   = 2'b00;
  assign s_axi_gmem.RLAST   = rlast;

  // Burst sequencer: arbitration, beat counting, registered channel outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      prio_write <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      beat       <= '0;
      idx        <= '0;
      rvalid     <= 1'b0;
      rlast      <= 1'b0;
      rdata      <= '0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_grant) begin
            id_q       <= s_axi_gmem.ARID;
            len_q      <= s_axi_gmem.ARLEN;
            beat       <= '0;
            idx        <= s_axi_gmem.ARADDR[IDX_W+5:6];
            prio_write <= ~prio_write;
            state      <= RD_FETCH;
          end else if (aw_grant) begin
            id_q       <= s_axi_gmem.AWID;
            len_q      <= s_axi_gmem.AWLEN;
            beat       <= '0;
            idx        <= s_axi_gmem.AWADDR[IDX_W+5:6];
            prio_write <= ~prio_write;
            wready     <= 1'b1;
            state      <= WR_DATA;
          end
        end

        RD_FETCH: begin
          // One-cycle RAM read; the beat is then held in rdata until accepted.
          rdata  <= mem[idx];
          rlast  <= last_beat;
          rvalid <= 1'b1;
          state  <= RD_DATA;
        end

        RD_DATA: begin
          if (s_axi_gmem.RREADY) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat  <= beat + 8'd1;
              idx   <= idx + 1'b1;
              state <= RD_FETCH;
            end
          end
        end

        WR_DATA: begin
          // The beat counter alone closes the burst; WLAST is not trusted.
          if (s_axi_gmem.WVALID) begin
            if (last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              state  <= WR_RESP;
            end else begin
              beat <= beat + 8'd1;
              idx  <= idx + 1'b1;
            end
          end
        end

        WR_RESP: begin
          if (s_axi_gmem.BREADY) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Byte-strobed RAM write port; contents are deliberately left out of reset.
  always_ff @(posedge ap_clk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_gmem.WSTRB[b]) begin
          mem[idx][b*8 +: 8] <= s_axi_gmem.WDATA[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_gmem_bram_responder.sv
// tb/tb_gmem_bram_responder.sv - self-checking bench for gmem_bram_responder against a line-array model
module tb_gmem_bram_responder;

  logic clk;
  logic rst;

  gmem_bram_responder_if #(.ID_WIDTH(1), .ADDR_WIDTH(42), .DATA_WIDTH(512)) gm ();

  gmem_bram_responder #(
    .C_M_AXI_GMEM_ID_WIDTH   (1),
    .C_M_AXI_GMEM_ADDR_WIDTH (42),
    .C_M_AXI_GMEM_DATA_WIDTH (512),
    .MEM_DEPTH_LOG2          (10)
  ) dut (
    .ap_clk     (clk),
    .ap_rst     (rst),
    .s_axi_gmem (gm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp;
  int nfail;

  logic [511:0] model_mem [0:1023];
  bit           model_prio_write;

  logic [511:0] wdat [0:255];
  logic [63:0]  wstr [0:255];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [41:0] a, input int k);
    return int'(((a / 42'd64) + 42'(k)) % 42'd1024);
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic idle_inputs();
    gm.AWVALID = 1'b0; gm.AWADDR = '0; gm.AWID = '0; gm.AWLEN = '0;
    gm.WVALID  = 1'b0; gm.WDATA  = '0; gm.WSTRB = '0; gm.WLAST = 1'b0;
    gm.BREADY  = 1'b0;
    gm.ARVALID = 1'b0; gm.ARADDR = '0; gm.ARID = '0; gm.ARLEN = '0;
    gm.RREADY  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string ctx);
    #1;
    chk({ctx, "_awready"}, gm.AWREADY, 0);
    chk({ctx, "_arready"}, gm.ARREADY, 0);
    chk({ctx, "_wready"},  gm.WREADY,  0);
    chk({ctx, "_bvalid"},  gm.BVALID,  0);
    chk({ctx, "_rvalid"},  gm.RVALID,  0);
    chk({ctx, "_rlast"},   gm.RLAST,   0);
    chk({ctx, "_rdata"},   gm.RDATA,   0);
    chk({ctx, "_rid"},     gm.RID,     0);
    chk({ctx, "_bid"},     gm.BID,     0);
    chk({ctx, "_rresp"},   gm.RRESP,   0);
    chk({ctx, "_bresp"},   gm.BRESP,   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_prio_write = 1'b0;
    check_reset_outputs("reset");
  endtask

  // Writes wdat/wstr[0..len]; abort_beat >= 0 pulses reset alongside that beat.
  task automatic do_write(input logic [41:0] addr, input logic id, input int len,
                          input int bstall, input bit both, input int abort_beat);
    int ln;
    @(negedge clk);
    gm.AWVALID = 1'b1; gm.AWADDR = addr; gm.AWID = id; gm.AWLEN = 8'(len);
    if (both) begin
      gm.ARVALID = 1'b1; gm.ARADDR = 42'($urandom()); gm.ARID = 1'($urandom()); gm.ARLEN = 8'd0;
    end
    #1;
    chk("aw_grant", gm.AWREADY, 1);
    chk("aw_excl_arready", gm.ARREADY, 0);
    model_prio_write = !model_prio_write;
    @(negedge clk);
    gm.AWVALID = 1'b0; gm.ARVALID = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        gm.WVALID = 1'b0;
        #1;
        chk("wready_gap", gm.WREADY, 1);
        @(negedge clk);
      end
      gm.WVALID = 1'b1; gm.WDATA = wdat[k]; gm.WSTRB = wstr[k]; gm.WLAST = (k == len);
      if (k == abort_beat) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_prio_write = 1'b0;
        check_reset_outputs("abort");
        return;
      end
      #1;
      chk("wready", gm.WREADY, 1);
      chk("bvalid_early", gm.BVALID, 0);
      ln = line_of(addr, k);
      for (int b = 0; b < 64; b++)
        if (wstr[k][b]) model_mem[ln][b*8 +: 8] = wdat[k][b*8 +: 8];
      @(negedge clk);
    end
    gm.WVALID = 1'b0; gm.WLAST = 1'b0;
    #1;
    chk("bvalid", gm.BVALID, 1);
    chk("bid", gm.BID, id);
    chk("bresp", gm.BRESP, 0);
    chk("wready_done", gm.WREADY, 0);
    for (int s = 0; s < bstall; s++) begin
      @(negedge clk);
      #1;
      chk("bvalid_hold", gm.BVALID, 1);
      chk("bid_hold", gm.BID, id);
    end
    gm.BREADY = 1'b1;
    @(negedge clk);
    gm.BREADY = 1'b0;
    #1;
    chk("bvalid_clear", gm.BVALID, 0);
  endtask

  task automatic do_read(input logic [41:0] addr, input logic id, input int len,
                         input int stall_beat, input int stall_cyc, input bit both);
    logic [511:0] exp;
    @(negedge clk);
    gm.ARVALID = 1'b1; gm.ARADDR = addr; gm.ARID = id; gm.ARLEN = 8'(len);
    if (both) begin
      gm.AWVALID = 1'b1; gm.AWADDR = 42'($urandom()); gm.AWID = 1'($urandom()); gm.AWLEN = 8'd0;
    end
    #1;
    chk("ar_grant", gm.ARREADY, 1);
    chk("ar_excl_awready", gm.AWREADY, 0);
    model_prio_write = !model_prio_write;
    @(negedge clk);
    gm.ARVALID = 1'b0; gm.AWVALID = 1'b0;
    #1;
    chk("r_fetch_gap", gm.RVALID, 0);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      #1;
      exp = model_mem[line_of(addr, k)];
      chk("rvalid", gm.RVALID, 1);
      chk("rdata", gm.RDATA, exp);
      chk("rlast", gm.RLAST, (k == len));
      chk("rid", gm.RID, id);
      chk("rresp", gm.RRESP, 0);
      if (k == stall_beat) begin
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk);
          #1;
          chk("rvalid_hold", gm.RVALID, 1);
          chk("rdata_hold", gm.RDATA, exp);
          chk("rlast_hold", gm.RLAST, (k == len));
        end
      end
      gm.RREADY = 1'b1;
      @(negedge clk);
      gm.RREADY = 1'b0;
      #1;
      chk("r_gap", gm.RVALID, 0);
    end
  endtask

  initial begin
    logic [41:0] a;
    int          len;
    bit          both;
    bit          is_write;
    ncmp = 0;
    nfail = 0;
    rst = 1'b1;
    model_prio_write = 1'b0;
    idle_inputs();

    // Reset state
    do_reset();

    // Fill the whole RAM with random lines so every model entry is defined
    for (int blk = 0; blk < 4; blk++) begin
      for (int k = 0; k < 256; k++) begin
        wdat[k] = rand_line();
        wstr[k] = '1;
      end
      do_write(42'(blk * 256 * 64), 1'b0, 255, 0, 1'b0, -1);
    end

    // Single read of line 5 holding the 0xA5 pattern
    wdat[0] = {64{8'hA5}};
    wstr[0] = '1;
    do_write(42'h140, 1'b0, 0, 0, 1'b0, -1);
    do_read(42'h140, 1'b1, 0, -1, 0, 1'b0);
    chk("line5_pattern", model_mem[5], {64{8'hA5}});

    // 4-beat full-strobe write with B backpressure, then read back with R backpressure
    for (int k = 0; k < 4; k++) begin
      wdat[k] = {16{32'(k)}};
      wstr[k] = '1;
    end
    do_write(42'h0, 1'b1, 3, 3, 1'b0, -1);
    do_read(42'h0, 1'b0, 3, 1, 5, 1'b0);

    // Partial strobe on line 2 preloaded with all-ones
    wdat[0] = '1;
    wstr[0] = '1;
    do_write(42'h80, 1'b0, 0, 0, 1'b0, -1);
    wdat[0] = rand_line();
    wstr[0] = 64'h0000_0000_0000_00FF;
    do_write(42'h80, 1'b1, 0, 1, 1'b0, -1);
    do_read(42'h80, 1'b1, 0, -1, 0, 1'b0);
    chk("partial_upper_ff", model_mem[2][511:64], {56{8'hFF}});

    // Simultaneous requests after reset: read first (with index wrap), then write
    do_reset();
    do_read(42'hFFC0, 1'b1, 1, 0, 2, 1'b1);
    wdat[0] = rand_line();
    wstr[0] = '1;
    do_write(42'h1_0000, 1'b1, 0, 0, 1'b1, -1);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      a = 42'({$urandom(), $urandom()});
      len = $urandom_range(0, 15);
      both = ($urandom_range(0, 2) == 0);
      is_write = both ? model_prio_write : 1'($urandom());
      if (is_write) begin
        for (int k = 0; k <= len; k++) begin
          wdat[k] = rand_line();
          wstr[k] = ($urandom_range(0, 1) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom(), $urandom()};
        end
        do_write(a, 1'($urandom()), len, $urandom_range(0, 3), both, -1);
      end else begin
        do_read(a, 1'($urandom()), len, $urandom_range(0, 15), $urandom_range(0, 4), both);
      end
    end

    // Reset during beat 2 of an 8-beat write, then read lines 0-7 back
    do_read(42'h40, 1'b1, 0, -1, 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      wdat[k] = rand_line();
      wstr[k] = '1;
    end
    do_write(42'h0, 1'b1, 7, 0, 1'b0, 2);
    do_read(42'h0, 1'b0, 7, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
